// File: rtl/counter_controller_if.sv
// Front-panel bundle between the board keys/divider tick and the counter control outputs.
// The master drives keys and tick; the slave is the controller.
interface counter_controller_if;
    logic        i_btn_start;
    logic        i_btn_load;
    logic        i_btn_dir;
    logic        i_btn_type;
    logic        i_tick;
    logic        o_set;
    logic        o_pause;
    logic        o_count;
    logic        o_type;
    logic [1:0]  o_state;
    logic [15:0] o_steps;

    modport master (
        output i_btn_start, i_btn_load, i_btn_dir, i_btn_type, i_tick,
        input  o_set, o_pause, o_count, o_type, o_state, o_steps
    );

    modport slave (
        input  i_btn_start, i_btn_load, i_btn_dir, i_btn_type, i_tick,
        output o_set, o_pause, o_count, o_type, o_state, o_steps
    );
endinterface

// File: rtl/counter_controller.sv
// Front-panel sequencer: debounces four active-low keys and runs the
// idle/load/run/paused state machine that drives the counter controls.
module counter_controller #(
    parameter int unsigned DebounceCycles = 500000,
    parameter int unsigned RunSteps       = 0
) (
    input  logic          i_clk,
    input  logic          i_reset,
    counter_controller_if.slave io_ctrl
);

    localparam int unsigned     CntW      = (DebounceCycles > 1) ? $clog2(DebounceCycles) : 1;
    localparam logic [CntW-1:0] CntLast   = CntW'(DebounceCycles - 1);
    localparam logic [15:0]     LastStep  = 16'(RunSteps - 1);
    localparam bit              AutoPause = (RunSteps != 0);

    localparam int BtnStart = 0;
    localparam int BtnLoad  = 1;
    localparam int BtnDir   = 2;
    localparam int BtnType  = 3;

    typedef enum logic [1:0] {
        StIdle   = 2'b00,
        StLoad   = 2'b01,
        StRun    = 2'b10,
        StPaused = 2'b11
    } state_e;

    logic [3:0]      w_btn_raw;
    logic [3:0]      r_sync1;
    logic [3:0]      r_sync2;
    logic [3:0]      r_db;
    logic [3:0]      r_db_q;
    logic [3:0]      r_press;
    logic [CntW-1:0] r_cnt [4];

    assign w_btn_raw = {io_ctrl.i_btn_type, io_ctrl.i_btn_dir,
                        io_ctrl.i_btn_load, io_ctrl.i_btn_start};

    // Debounced levels reset to released, so a key held through reset still yields one press.
    always_ff @(posedge i_clk) begin
        if (!i_reset) begin
            r_sync1 <= 4'hF;
            r_sync2 <= 4'hF;
            r_db    <= 4'hF;
            r_db_q  <= 4'hF;
            r_press <= 4'h0;
            for (int i = 0; i < 4; i++) begin
                r_cnt[i] <= '0;
            end
        end else begin
            r_sync1 <= w_btn_raw;
            r_sync2 <= r_sync1;
            r_db_q  <= r_db;
            r_press <= r_db_q & ~r_db;
            for (int i = 0; i < 4; i++) begin
                if (r_sync2[i] == r_db[i]) begin
                    r_cnt[i] <= '0;
                end else if (r_cnt[i] == CntLast) begin
                    r_cnt[i] <= '0;
                    r_db[i]  <= r_sync2[i];
                end else begin
                    r_cnt[i] <= r_cnt[i] + 1'b1;
                end
            end
        end
    end

    logic w_press_start;
    logic w_press_load;
    logic w_press_dir;
    logic w_press_type;

    assign w_press_start = r_press[BtnStart];
    assign w_press_load  = r_press[BtnLoad];
    assign w_press_dir   = r_press[BtnDir];
    assign w_press_type  = r_press[BtnType];

    state_e      r_state;
    state_e      r_target;
    logic        r_set;
    logic        r_pause;
    logic        r_count;
    logic        r_type;
    logic [15:0] r_steps;

    always_ff @(posedge i_clk) begin
        if (!i_reset) begin
            r_state  <= StIdle;
            r_target <= StRun;
            r_set    <= 1'b0;
            r_pause  <= 1'b1;
            r_count  <= 1'b1;
            r_type   <= 1'b0;
            r_steps  <= '0;
        end else begin
            if (w_press_dir) begin
                r_count <= ~r_count;
            end
            if (w_press_type) begin
                r_type <= ~r_type;
            end

            if (w_press_load && (r_state != StLoad)) begin
                r_state  <= StLoad;
                r_target <= StPaused;
                r_set    <= 1'b1;
                r_pause  <= 1'b1;
                r_steps  <= '0;
            end else begin
                case (r_state)
                    StIdle: begin
                        if (w_press_start) begin
                            r_state  <= StLoad;
                            r_target <= StRun;
                            r_set    <= 1'b1;
                            r_pause  <= 1'b1;
                            r_steps  <= '0;
                        end
                    end
                    // o_set is held until the slow counter has seen a tick.
                    StLoad: begin
                        if (io_ctrl.i_tick) begin
                            r_state <= r_target;
                            r_set   <= 1'b0;
                            r_pause <= (r_target != StRun);
                        end
                    end
                    StRun: begin
                        if (io_ctrl.i_tick && (r_steps != 16'hFFFF)) begin
                            r_steps <= r_steps + 16'd1;
                        end
                        if (w_press_start ||
                            (AutoPause && io_ctrl.i_tick && (r_steps == LastStep))) begin
                            r_state <= StPaused;
                            r_pause <= 1'b1;
                        end
                    end
                    StPaused: begin
                        if (w_press_start) begin
                            r_state <= StRun;
                            r_pause <= 1'b0;
                            r_steps <= '0;
                        end
                    end
                    default: begin
                        r_state <= StIdle;
                    end
                endcase
            end
        end
    end

    assign io_ctrl.o_set   = r_set;
    assign io_ctrl.o_pause = r_pause;
    assign io_ctrl.o_count = r_count;
    assign io_ctrl.o_type  = r_type;
    assign io_ctrl.o_state = r_state;
    assign io_ctrl.o_steps = r_steps;

endmodule

// File: tb/tb_counter_controller.sv
// Directed bench for counter_controller: one DUT with RunSteps=4, a twin with
// unlimited steps sharing the same stimulus.
module tb_counter_controller;

    localparam logic [3:0] BtnStart = 4'b0001;
    localparam logic [3:0] BtnLoad  = 4'b0010;
    localparam logic [3:0] BtnDir   = 4'b0100;
    localparam logic [3:0] BtnType  = 4'b1000;

    logic       clk = 1'b0;
    logic       rst_n;
    logic [3:0] btn;
    logic       tick;
    int         n_checks = 0;
    int         n_fail   = 0;

    always #5 clk = ~clk;

    counter_controller_if u_if ();
    counter_controller_if u_if_u ();

    assign u_if.i_btn_start   = btn[0];
    assign u_if.i_btn_load    = btn[1];
    assign u_if.i_btn_dir     = btn[2];
    assign u_if.i_btn_type    = btn[3];
    assign u_if.i_tick        = tick;
    assign u_if_u.i_btn_start = btn[0];
    assign u_if_u.i_btn_load  = btn[1];
    assign u_if_u.i_btn_dir   = btn[2];
    assign u_if_u.i_btn_type  = btn[3];
    assign u_if_u.i_tick      = tick;

    counter_controller #(.DebounceCycles(4), .RunSteps(4)) u_dut (
        .i_clk   (clk),
        .i_reset (rst_n),
        .io_ctrl (u_if.slave)
    );

    counter_controller #(.DebounceCycles(4), .RunSteps(0)) u_dut_u (
        .i_clk   (clk),
        .i_reset (rst_n),
        .io_ctrl (u_if_u.slave)
    );

    // Advance n active edges and land 1 time unit after the last one.
    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic press(input logic [3:0] mask);
        btn = ~mask;
        step(12);
        btn = 4'hF;
        step(10);
    endtask

    task automatic pulse_tick();
        tick = 1'b1;
        step(1);
        tick = 1'b0;
        step(2);
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        btn   = 4'hF;
        tick  = 1'b0;
        step(3);
        rst_n = 1'b1;
        step(20);
        n_checks++; if (u_if.o_pause !== 1'b1) begin n_fail++; $display("FAIL reset_pause got=%0h exp=1", u_if.o_pause); end
        n_checks++; if (u_if.o_set !== 1'b0) begin n_fail++; $display("FAIL reset_set got=%0h exp=0", u_if.o_set); end
        n_checks++; if (u_if.o_count !== 1'b1) begin n_fail++; $display("FAIL reset_count got=%0h exp=1", u_if.o_count); end
        n_checks++; if (u_if.o_type !== 1'b0) begin n_fail++; $display("FAIL reset_type got=%0h exp=0", u_if.o_type); end
        n_checks++; if (u_if.o_state !== 2'b00) begin n_fail++; $display("FAIL reset_state got=%0h exp=0", u_if.o_state); end
        n_checks++; if (u_if.o_steps !== 16'd0) begin n_fail++; $display("FAIL reset_steps got=%0d exp=0", u_if.o_steps); end
    endtask

    task automatic test_debounce();
        btn = ~BtnStart;
        step(3);
        btn = 4'hF;
        step(12);
        n_checks++; if (u_if.o_state !== 2'b00) begin n_fail++; $display("FAIL glitch_state got=%0h exp=0", u_if.o_state); end
        n_checks++; if (u_if.o_set !== 1'b0) begin n_fail++; $display("FAIL glitch_set got=%0h exp=0", u_if.o_set); end
        btn = ~BtnStart;
        step(7);
        n_checks++; if (u_if.o_state !== 2'b00) begin n_fail++; $display("FAIL latency_early got=%0h exp=0", u_if.o_state); end
        step(1);
        n_checks++; if (u_if.o_state !== 2'b01) begin n_fail++; $display("FAIL latency_load got=%0h exp=1", u_if.o_state); end
        n_checks++; if (u_if.o_set !== 1'b1) begin n_fail++; $display("FAIL latency_set got=%0h exp=1", u_if.o_set); end
        step(4);
        btn = 4'hF;
        step(10);
    endtask

    task automatic test_run();
        n_checks++; if (u_if.o_state !== 2'b01) begin n_fail++; $display("FAIL hold_load_state got=%0h exp=1", u_if.o_state); end
        n_checks++; if (u_if.o_set !== 1'b1) begin n_fail++; $display("FAIL hold_load_set got=%0h exp=1", u_if.o_set); end
        n_checks++; if (u_if.o_pause !== 1'b1) begin n_fail++; $display("FAIL hold_load_pause got=%0h exp=1", u_if.o_pause); end
        pulse_tick();
        n_checks++; if (u_if.o_state !== 2'b10) begin n_fail++; $display("FAIL run_state got=%0h exp=2", u_if.o_state); end
        n_checks++; if (u_if.o_pause !== 1'b0) begin n_fail++; $display("FAIL run_pause got=%0h exp=0", u_if.o_pause); end
        n_checks++; if (u_if.o_set !== 1'b0) begin n_fail++; $display("FAIL run_set got=%0h exp=0", u_if.o_set); end
        repeat (3) pulse_tick();
        n_checks++; if (u_if.o_steps !== 16'd3) begin n_fail++; $display("FAIL run_steps got=%0d exp=3", u_if.o_steps); end
        n_checks++; if (u_if_u.o_steps !== 16'd3) begin n_fail++; $display("FAIL run_steps_u got=%0d exp=3", u_if_u.o_steps); end
        press(BtnStart);
        n_checks++; if (u_if.o_state !== 2'b11) begin n_fail++; $display("FAIL stop_state got=%0h exp=3", u_if.o_state); end
        n_checks++; if (u_if.o_pause !== 1'b1) begin n_fail++; $display("FAIL stop_pause got=%0h exp=1", u_if.o_pause); end
        n_checks++; if (u_if.o_steps !== 16'd3) begin n_fail++; $display("FAIL stop_steps got=%0d exp=3", u_if.o_steps); end
    endtask

    task automatic test_autopause();
        logic [15:0] exp_steps;
        logic [1:0]  exp_state;
        press(BtnStart);
        n_checks++; if (u_if.o_state !== 2'b10) begin n_fail++; $display("FAIL resume_state got=%0h exp=2", u_if.o_state); end
        n_checks++; if (u_if.o_steps !== 16'd0) begin n_fail++; $display("FAIL resume_steps got=%0d exp=0", u_if.o_steps); end
        for (int i = 1; i <= 6; i++) begin
            pulse_tick();
            exp_steps = (i < 4) ? 16'(i) : 16'd4;
            exp_state = (i < 4) ? 2'b10 : 2'b11;
            n_checks++; if (u_if.o_steps !== exp_steps) begin n_fail++; $display("FAIL auto_steps[%0d] got=%0d exp=%0d", i, u_if.o_steps, exp_steps); end
            n_checks++; if (u_if.o_state !== exp_state) begin n_fail++; $display("FAIL auto_state[%0d] got=%0h exp=%0h", i, u_if.o_state, exp_state); end
            n_checks++; if (u_if_u.o_steps !== 16'(i)) begin n_fail++; $display("FAIL unlim_steps[%0d] got=%0d exp=%0d", i, u_if_u.o_steps, i); end
            n_checks++; if (u_if_u.o_state !== 2'b10) begin n_fail++; $display("FAIL unlim_state[%0d] got=%0h exp=2", i, u_if_u.o_state); end
        end
    endtask

    task automatic test_load_dir();
        press(BtnStart);
        repeat (2) pulse_tick();
        n_checks++; if (u_if.o_steps !== 16'd2) begin n_fail++; $display("FAIL pre_load_steps got=%0d exp=2", u_if.o_steps); end
        n_checks++; if (u_if_u.o_state !== 2'b11) begin n_fail++; $display("FAIL pre_load_state_u got=%0h exp=3", u_if_u.o_state); end
        press(BtnLoad | BtnDir);
        n_checks++; if (u_if.o_state !== 2'b01) begin n_fail++; $display("FAIL ld_state got=%0h exp=1", u_if.o_state); end
        n_checks++; if (u_if.o_set !== 1'b1) begin n_fail++; $display("FAIL ld_set got=%0h exp=1", u_if.o_set); end
        n_checks++; if (u_if.o_count !== 1'b0) begin n_fail++; $display("FAIL ld_count got=%0h exp=0", u_if.o_count); end
        n_checks++; if (u_if.o_steps !== 16'd0) begin n_fail++; $display("FAIL ld_steps got=%0d exp=0", u_if.o_steps); end
        n_checks++; if (u_if_u.o_state !== 2'b01) begin n_fail++; $display("FAIL ld_state_u got=%0h exp=1", u_if_u.o_state); end
        pulse_tick();
        n_checks++; if (u_if.o_state !== 2'b11) begin n_fail++; $display("FAIL ld_exit_state got=%0h exp=3", u_if.o_state); end
        n_checks++; if (u_if.o_steps !== 16'd0) begin n_fail++; $display("FAIL ld_exit_steps got=%0d exp=0", u_if.o_steps); end
        n_checks++; if (u_if.o_set !== 1'b0) begin n_fail++; $display("FAIL ld_exit_set got=%0h exp=0", u_if.o_set); end
        n_checks++; if (u_if.o_pause !== 1'b1) begin n_fail++; $display("FAIL ld_exit_pause got=%0h exp=1", u_if.o_pause); end
    endtask

    task automatic test_back_to_back();
        press(BtnStart);
        btn = ~BtnStart;
        step(7);
        tick = 1'b1;
        step(1);
        tick = 1'b0;
        n_checks++; if (u_if.o_state !== 2'b11) begin n_fail++; $display("FAIL tick_stop_state got=%0h exp=3", u_if.o_state); end
        n_checks++; if (u_if.o_steps !== 16'd1) begin n_fail++; $display("FAIL tick_stop_steps got=%0d exp=1", u_if.o_steps); end
        n_checks++; if (u_if_u.o_steps !== 16'd1) begin n_fail++; $display("FAIL tick_stop_steps_u got=%0d exp=1", u_if_u.o_steps); end
        step(4);
        btn = 4'hF;
        step(10);
        press(BtnStart | BtnLoad);
        n_checks++; if (u_if.o_state !== 2'b01) begin n_fail++; $display("FAIL prio_state got=%0h exp=1", u_if.o_state); end
        press(BtnStart);
        n_checks++; if (u_if.o_state !== 2'b01) begin n_fail++; $display("FAIL load_ignore_start got=%0h exp=1", u_if.o_state); end
        pulse_tick();
        n_checks++; if (u_if.o_state !== 2'b11) begin n_fail++; $display("FAIL prio_target got=%0h exp=3", u_if.o_state); end
    endtask

    task automatic test_reset_load();
        press(BtnLoad);
        n_checks++; if (u_if.o_state !== 2'b01) begin n_fail++; $display("FAIL rl_pre_state got=%0h exp=1", u_if.o_state); end
        rst_n = 1'b0;
        step(1);
        n_checks++; if (u_if.o_state !== 2'b00) begin n_fail++; $display("FAIL rl_state got=%0h exp=0", u_if.o_state); end
        n_checks++; if (u_if.o_set !== 1'b0) begin n_fail++; $display("FAIL rl_set got=%0h exp=0", u_if.o_set); end
        n_checks++; if (u_if.o_count !== 1'b1) begin n_fail++; $display("FAIL rl_count got=%0h exp=1", u_if.o_count); end
        rst_n = 1'b1;
        step(5);
        press(BtnType);
        n_checks++; if (u_if.o_type !== 1'b1) begin n_fail++; $display("FAIL type_toggle got=%0h exp=1", u_if.o_type); end
        n_checks++; if (u_if.o_state !== 2'b00) begin n_fail++; $display("FAIL type_state got=%0h exp=0", u_if.o_state); end
        n_checks++; if (u_if.o_count !== 1'b1) begin n_fail++; $display("FAIL type_count got=%0h exp=1", u_if.o_count); end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        test_reset();
        test_debounce();
        test_run();
        test_autopause();
        test_load_dir();
        test_back_to_back();
        test_reset_load();
        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/counter_controller.md
# counter_controller

Front-panel sequencer for the counter datapath. Debounces four raw push-buttons and runs a small run/pause/load state machine. Drives the counter's set, pause, count-direction and display-type controls, and can stop automatically after a programmed number of steps. Sits between the board keys and the counter/rsp pair, in the 50 MHz domain, and uses the clock divider's step pulse as its tick.

## Interface
- DebounceCycles, 500000, consecutive stable cycles required to accept a button level (10 ms at 50 MHz); minimum 1
- RunSteps, 0, steps executed in RUN before auto-pause; 0 = unlimited; range 0..65535
- i_clk  in  1  system clock (50 MHz)
- i_reset  in  1  synchronous, active-low reset
- i_btn_start  in  1  raw start/stop key, active-low, asynchronous to i_clk
- i_btn_load  in  1  raw load-initial-value key, active-low, asynchronous
- i_btn_dir  in  1  raw count-direction toggle key, active-low, asynchronous
- i_btn_type  in  1  raw BIN/DEC toggle key, active-low, asynchronous
- i_tick  in  1  one-cycle step pulse from clock divider, synchronous to i_clk
- o_set  out  1  load initial value into counter
- o_pause  out  1  hold counter
- o_count  out  1  1 = increment, 0 = shift left
- o_type  out  1  1 = DEC, 0 = BIN
- o_state  out  2  current FSM state encoding
- o_steps  out  16  steps taken in current run

## Operation
- Per button: 2-flop synchronizer, then debounce counter. The debounced level changes only after DebounceCycles consecutive cycles in which the synchronized value differs from the current debounced level. Any bounce restarts the count.
- Debounced levels reset to 1 (released). A press is a one-cycle pulse on the debounced 1->0 edge. Release generates nothing.
- A key held through reset yields exactly one press after the debounce delay.
- FSM states and encoding:
  - IDLE=00: o_pause=1, o_set=0
  - LOAD=01: o_pause=1, o_set=1
  - RUN=10: o_pause=0, o_set=0
  - PAUSED=11: o_pause=1, o_set=0
- Transitions, evaluated in priority order per cycle:
  - load press in any state except LOAD -> LOAD, with target PAUSED
  - IDLE + start press -> LOAD, with target RUN
  - LOAD + i_tick -> target state; the target is latched on entry to LOAD
  - RUN + start press -> PAUSED
  - RUN + i_tick with RunSteps!=0 and o_steps==RunSteps-1 -> PAUSED, and o_steps increments to RunSteps on that tick
  - PAUSED + start press -> RUN
- In LOAD, start presses are ignored.
- o_set is held until i_tick so the slow-clocked counter samples it. That handshake is the only way out of LOAD.
- o_steps:
  - cleared on entry to LOAD and on each PAUSED->RUN transition
  - increments on i_tick only in RUN
  - saturates at 65535 when RunSteps=0
- o_count toggles on a dir press and o_type toggles on a type press, in every state. Both are independent of the FSM and of each other.
- Simultaneous presses are all honored in the same cycle: load wins over start; dir and type apply alongside.

## Timing
- Reset values: o_set=0, o_pause=1, o_count=1, o_type=0, o_state=00, o_steps=0. All debounce counters are 0.
- Reset active mid-LOAD or mid-RUN returns to IDLE on the next edge, with o_set deasserted.
- Press latency: a raw edge becomes a debounced pulse 2 sync cycles + DebounceCycles + 1 edge-detect cycle later. The FSM and toggles update on the following edge.
- All outputs are registered, with no combinational path from inputs to outputs.
- LOAD lasts from its entry edge until the edge after the first i_tick is sampled, so o_set stays high for at least 1 cycle and at most 1 divider period.
- An i_tick in the same cycle as the RUN->PAUSED start press still increments o_steps.

## Test plan
- DebounceCycles=4. Reset, then hold reset high 20 cycles -> o_pause=1, o_set=0, o_count=1, o_type=0, o_state=00, o_steps=0.
- Glitch i_btn_start low for 3 cycles -> no state change. Hold it low for 10 cycles -> LOAD entered exactly 2+4+2 cycles after the falling edge.
- From IDLE press start. Pulse i_tick 5 cycles later -> o_set=1 for those cycles, then RUN with o_pause=0. Three ticks -> o_steps=3. Press start -> PAUSED with o_steps held at 3.
- RunSteps=4. From RUN issue 6 ticks -> PAUSED after the 4th tick, o_steps=4, and the remaining ticks are ignored.
- Press load and dir in the same cycle during RUN -> LOAD with o_count flipped to 0. i_tick -> PAUSED with o_steps=0.
- Assert reset while in LOAD -> next edge gives o_state=00 and o_set=0. A press on type -> o_type=1 in IDLE.
